// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result stream bundle for the pipelined carry-lookahead adder/subtractor.
// Handshake: a beat moves across a channel on a rising clock edge exactly when
// valid and ready are both 1 on that edge. A producer keeps its data stable while
// valid=1 and ready=0. Ready may depend on the consumer's state but never on valid.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // Operand source and result sink side.
  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Operands are cut into BLOCK-bit
// groups; each register stage resolves GPS consecutive groups and hands the
// boundary carry, the still-unresolved operand bits and the partial sum onward.
// All stages advance together whenever the output slot is free or being consumed.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  pipelined_cla_addsub_if.slave  io_bus
);

  localparam int N_GRP = WIDTH / BLOCK;
  localparam int GPS   = (N_GRP + STAGES - 1) / STAGES;
  localparam int LAST  = STAGES - 1;

  // Reject parameter combinations that cannot be split into groups and stages.
  generate
    if ((BLOCK < 1) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_bad_width
      $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
    end
    if ((STAGES < 1) || (STAGES > N_GRP)) begin : g_bad_stages
      $error("pipelined_cla_addsub: STAGES must lie in 1..WIDTH/BLOCK");
    end
  endgenerate

  // Stage inputs (what each stage's lookahead logic sees this cycle).
  logic [WIDTH-1:0] w_ia  [STAGES];
  logic [WIDTH-1:0] w_ib  [STAGES];
  logic [WIDTH-1:0] w_is  [STAGES];
  logic             w_iv  [STAGES];
  logic             w_ic  [STAGES];
  logic             w_icm [STAGES];

  // Stage results (loaded into the stage register on an advancing edge).
  logic [WIDTH-1:0] w_ns  [STAGES];
  logic             w_nc  [STAGES];
  logic             w_ncm [STAGES];

  // Stage registers: operands, partial sum, boundary carry, carry into the MSB.
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_v   [STAGES];
  logic             r_c   [STAGES];
  logic             r_cm  [STAGES];
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;

  // The whole pipe moves when the output slot is empty or being drained.
  assign w_adv = io_bus.out_ready | ~r_v[LAST];

  assign io_bus.in_ready  = w_adv;
  assign io_bus.out_valid = r_v[LAST];
  assign io_bus.sum       = r_s[LAST];
  assign io_bus.cout      = r_c[LAST];
  assign io_bus.ovf       = r_ovf;
  assign io_bus.zero      = r_zero;

  // Stage 0 takes prepared operands (B inverted and carry flipped for subtract);
  // later stages take the previous stage's registers.
  always_comb begin
    w_iv[0]  = io_bus.in_valid;
    w_ia[0]  = io_bus.a;
    w_ib[0]  = io_bus.sub ? ~io_bus.b : io_bus.b;
    w_is[0]  = '0;
    w_ic[0]  = io_bus.carry_in ^ io_bus.sub;
    w_icm[0] = 1'b0;
    for (int s = 1; s < STAGES; s++) begin
      w_iv[s]  = r_v[s-1];
      w_ia[s]  = r_a[s-1];
      w_ib[s]  = r_b[s-1];
      w_is[s]  = r_s[s-1];
      w_ic[s]  = r_c[s-1];
      w_icm[s] = r_cm[s-1];
    end
  end

  // Each stage resolves its own groups: group P/G are formed from the operand bits
  // alone, the group carry is G | P&cin, and the group's sum bits use its carry-in.
  always_comb begin
    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic             w_gg;
    logic             w_pp;
    logic             w_c;
    logic             w_ci;
    w_p  = '0;
    w_g  = '0;
    w_gg = 1'b0;
    w_pp = 1'b0;
    w_c  = 1'b0;
    w_ci = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      w_ns[s]  = w_is[s];
      w_ncm[s] = w_icm[s];
      w_c      = w_ic[s];
      for (int j = 0; j < N_GRP; j++) begin
        if ((j / GPS) == s) begin
          w_p  = w_ia[s][j*BLOCK +: BLOCK] ^ w_ib[s][j*BLOCK +: BLOCK];
          w_g  = w_ia[s][j*BLOCK +: BLOCK] & w_ib[s][j*BLOCK +: BLOCK];
          w_pp = &w_p;
          w_gg = 1'b0;
          for (int i = 0; i < BLOCK; i++) begin
            w_gg = w_g[i] | (w_p[i] & w_gg);
          end
          w_ci = w_c;
          for (int i = 0; i < BLOCK; i++) begin
            w_ns[s][j*BLOCK+i] = w_p[i] ^ w_ci;
            if ((j == N_GRP - 1) && (i == BLOCK - 1)) begin
              w_ncm[s] = w_ci;
            end
            w_ci = w_g[i] | (w_p[i] & w_ci);
          end
          w_c = w_gg | (w_pp & w_c);
        end
      end
      w_nc[s] = w_c;
    end
  end

  // Stage registers shift together on advance; data is only loaded for valid beats
  // so the final stage keeps its last result while bubbles pass through.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s]  <= 1'b0;
        r_a[s]  <= '0;
        r_b[s]  <= '0;
        r_s[s]  <= '0;
        r_c[s]  <= 1'b0;
        r_cm[s] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s] <= w_iv[s];
        if (w_iv[s]) begin
          r_a[s]  <= w_ia[s];
          r_b[s]  <= w_ib[s];
          r_s[s]  <= w_ns[s];
          r_c[s]  <= w_nc[s];
          r_cm[s] <= w_ncm[s];
        end
      end
    end
  end

  // Overflow and zero flags are registered alongside the final-stage result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv && w_iv[LAST]) begin
      r_ovf  <= w_ncm[LAST] ^ w_nc[LAST];
      r_zero <= ~|w_ns[LAST];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed vector table, reset and backpressure
// sequences, random streaming against an arithmetic reference model, and a
// 16-bit / 4-stage instance for cross-stage carry propagation.
module tb_pipelined_cla_addsub;

  localparam int W = 35;  // {zero, ovf, cout, sum[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.WIDTH(32)) bus1 ();
  pipelined_cla_addsub_if #(.WIDTH(16)) bus2 ();

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(2)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus1)
  );

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus2)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  bit           mon_en = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    bit          cin;
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
    bit          zero;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the true (unsigned and signed) values.
  function automatic logic [W-1:0] model(input int w, input longint a, input longint b,
                                         input bit sub, input bit cin);
    longint      m;
    longint      r;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [31:0] s;
    bit          co;
    bit          ov;
    m  = longint'(1) << w;
    r  = sub ? (a - b - longint'(cin)) : (a + b + longint'(cin));
    co = sub ? (a >= b + longint'(cin)) : (r >= m);
    s  = 32'(r & (m - 1));
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sub ? (sa - sb - longint'(cin)) : (sa + sb + longint'(cin));
    ov = (sr >= m / 2) || (sr < -(m / 2));
    return {(s == 32'd0), ov, co, s};
  endfunction

  function automatic logic [W-1:0] act1();
    return {bus1.zero, bus1.ovf, bus1.cout, bus1.sum};
  endfunction

  function automatic logic [W-1:0] act2();
    return {bus2.zero, bus2.ovf, bus2.cout, 16'h0, bus2.sum};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input bit sub,
                        input bit cin, input bit v);
    bus1.a        = a;
    bus1.b        = b;
    bus1.sub      = sub;
    bus1.carry_in = cin;
    bus1.in_valid = v;
  endtask

  task automatic drive_rand1();
    drive1(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic drain1(input string name);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // One beat through the 4-stage instance: result must appear after exactly 4 edges.
  task automatic beat2(input string name, input logic [15:0] a, input logic [15:0] b,
                       input bit sub, input bit cin, input logic [W-1:0] exp);
    bus2.a        = a;
    bus2.b        = b;
    bus2.sub      = sub;
    bus2.carry_in = cin;
    bus2.in_valid = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk({name, "_early"}, 64'(bus2.out_valid), 64'd0);
      tick();
    end
    chk({name, "_valid"}, 64'(bus2.out_valid), 64'd1);
    chk(name, 64'(act2()), 64'(exp));
  endtask

  // ---------------- stream monitor (scoreboard) ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream_extra: got %0h expected no beat", act1());
        end else begin
          chk("stream", 64'(act1()), 64'(exp_q.pop_front()));
        end
      end
      if (bus1.in_valid && bus1.in_ready)
        exp_q.push_back(model(32, longint'(bus1.a), longint'(bus1.b), bus1.sub, bus1.carry_in));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    tbl[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'h1234_5678, 32'h0000_00FF, 1'b0, 1'b1, 32'h1234_5778, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};

    drive1(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus1.out_ready = 1'b1;
    bus2.a = '0; bus2.b = '0; bus2.sub = 1'b0; bus2.carry_in = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_outputs", 64'(act1()), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 64'(bus1.in_ready), 64'd1);

    // Directed table, one beat at a time with exact two-edge latency.
    for (int i = 0; i < 11; i++) begin
      drive1(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, 1'b1);
      tick();
      bus1.in_valid = 1'b0;
      chk($sformatf("tbl%0d_early", i), 64'(bus1.out_valid), 64'd0);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(bus1.out_valid), 64'd1);
      chk($sformatf("tbl%0d_result", i), 64'(act1()),
          64'({tbl[i].zero, tbl[i].ovf, tbl[i].cout, tbl[i].sum}));
    end
    tick();

    // Reset in the middle of a full, stalled pipe.
    bus1.out_ready = 1'b0;
    drive1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    tick();
    drive1(32'h3, 32'h4, 1'b0, 1'b0, 1'b1);
    tick();
    bus1.in_valid = 1'b0;
    chk("midrst_pre_valid", 64'(bus1.out_valid), 64'd1);
    chk("midrst_pre_flags", 64'({bus1.zero, bus1.cout}), 64'b11);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("midrst_outputs", 64'(act1()), 64'd0);
    tick();
    rst = 1'b0;
    bus1.out_ready = 1'b1;
    chk("midrst_in_ready", 64'(bus1.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_ghost", 64'(bus1.out_valid), 64'd0);
    end
    drive1(32'h2, 32'h3, 1'b0, 1'b0, 1'b1);
    tick();
    bus1.in_valid = 1'b0;
    tick();
    chk("postrst_result", 64'({bus1.out_valid, act1()}), 64'({1'b1, 3'b000, 32'h5}));
    tick();

    // 16 back-to-back beats: continuous output from the third cycle on.
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_rand1();
      if (i >= 2) chk("b2b_continuous", 64'(bus1.out_valid), 64'd1);
      tick();
    end
    bus1.in_valid = 1'b0;
    drain1("b2b_drain");

    // Backpressure with a full pipe: three stalled cycles, then release.
    bus1.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_rand1();
      tick();
    end
    drive_rand1();
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 64'(bus1.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus1.out_valid), 64'd1);
      chk("stall_frozen", 64'(act1()), 64'(exp_q[0]));
      tick();
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    drain1("stall_drain");

    // Random traffic with random backpressure.
    for (int k = 0; k < 200; k++) begin
      drive_rand1();
      bus1.in_valid  = 1'($urandom_range(0, 1));
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    drain1("rand_drain");
    mon_en = 1'b0;

    // 16-bit, 4-stage instance: carry must cross every stage boundary.
    beat2("s4_ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0});
    beat2("s4_sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFF});
    for (int k = 0; k < 6; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      bit          rs;
      bit          rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      beat2("s4_rand", ra, rb, rs, rc, model(16, longint'(ra), longint'(rb), rs, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
